// File: rtl/fmv_line_pixel_reader.sv
// rtl/fmv_line_pixel_reader.sv - FMV pixel FIFO read side with per-line alignment
// Pads short lines with BLACK, drains the excess of long lines, flags underflow/sync errors.
`timescale 1ns/1ps
module fmv_line_pixel_reader #(
   parameter int          DEPTH       = 16,
   parameter int          LINE_PIXELS = 352,
   parameter logic [23:0] BLACK       = 24'h000000
) (
   input  logic                     clk30,
   input  logic                     reset_n,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [23:0]              wr_data,
   input  logic                     wr_last,
   input  logic                     line_start,
   input  logic                     newpixel,
   input  logic                     clear_err,
   output logic                     pix_valid,
   output logic [23:0]              pix_rgb,
   output logic                     underflow,
   output logic                     sync_err,
   output logic [$clog2(DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LINE_PIXELS + 1);
   localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] LINE_END   = CW'(LINE_PIXELS);

   typedef enum logic [1:0] {IDLE, ACTIVE, SKIP} state_t;

   state_t        state, state_nx;
   logic [24:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] pix_cnt, pix_cnt_nx;
   logic          last_seen, last_seen_nx;
   logic          pad_flagged, pad_flagged_nx;
   logic          push, pop, empty;
   logic [24:0]   head;
   logic          set_under, set_sync, strobe_out, load_head;

   // Full/empty come from the registered level: no bypass in either direction.
   assign wr_ready = (fifo_level != FULL_LEVEL);
   assign empty    = (fifo_level == '0);
   assign push     = wr_valid && wr_ready;
   assign head     = mem[rd_ptr];

   always_comb begin
      state_nx       = state;
      pix_cnt_nx     = pix_cnt;
      last_seen_nx   = last_seen;
      pad_flagged_nx = pad_flagged;
      pop            = 1'b0;
      set_under      = 1'b0;
      set_sync       = 1'b0;
      strobe_out     = 1'b0;
      load_head      = 1'b0;
      if (line_start) begin
         state_nx       = ACTIVE;
         pix_cnt_nx     = '0;
         last_seen_nx   = 1'b0;
         pad_flagged_nx = 1'b0;
         set_sync       = (state != IDLE);
      end else begin
         case (state)
            ACTIVE: begin
               if (newpixel) begin
                  strobe_out = 1'b1;
                  pix_cnt_nx = pix_cnt + 1'b1;
                  if (last_seen) begin
                     set_sync       = !pad_flagged;
                     pad_flagged_nx = 1'b1;
                  end else if (empty) begin
                     set_under = 1'b1;
                  end else begin
                     pop          = 1'b1;
                     load_head    = 1'b1;
                     last_seen_nx = head[24];
                  end
                  if (pix_cnt_nx == LINE_END) begin
                     if (last_seen_nx) begin
                        state_nx = IDLE;
                     end else begin
                        state_nx = SKIP;
                        set_sync = 1'b1;
                     end
                  end
               end
            end
            SKIP: begin
               if (!empty) begin
                  pop = 1'b1;
                  if (head[24]) state_nx = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk30 or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         pix_cnt     <= '0;
         last_seen   <= 1'b0;
         pad_flagged <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_level  <= '0;
         pix_valid   <= 1'b0;
         pix_rgb     <= BLACK;
         underflow   <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state       <= state_nx;
         pix_cnt     <= pix_cnt_nx;
         last_seen   <= last_seen_nx;
         pad_flagged <= pad_flagged_nx;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         pix_valid <= strobe_out;
         if (strobe_out) pix_rgb <= load_head ? head[23:0] : BLACK;
         if (set_under)      underflow <= 1'b1;
         else if (clear_err) underflow <= 1'b0;
         if (set_sync)       sync_err <= 1'b1;
         else if (clear_err) sync_err <= 1'b0;
      end
   end

   always_ff @(posedge clk30) begin
      if (push) mem[wr_ptr] <= {wr_last, wr_data};
   end
endmodule

// File: tb/tb_fmv_line_pixel_reader.sv
// tb/tb_fmv_line_pixel_reader.sv - scoreboard bench for fmv_line_pixel_reader
`timescale 1ns/1ps
module tb_fmv_line_pixel_reader;
   localparam int          DEPTH = 16;
   localparam int          LINE  = 352;
   localparam logic [23:0] BLACK = 24'h000000;

   logic        clk30 = 1'b0;
   logic        reset_n = 1'b0;
   logic        wr_valid = 1'b0, wr_last = 1'b0, line_start = 1'b0, newpixel = 1'b0, clear_err = 1'b0;
   logic [23:0] wr_data = '0;
   logic        wr_ready, pix_valid, underflow, sync_err;
   logic [23:0] pix_rgb;
   logic [4:0]  fifo_level;

   fmv_line_pixel_reader #(.DEPTH(DEPTH), .LINE_PIXELS(LINE), .BLACK(BLACK)) dut (
      .clk30(clk30), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .wr_last(wr_last), .line_start(line_start), .newpixel(newpixel),
      .clear_err(clear_err), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
      .underflow(underflow), .sync_err(sync_err), .fifo_level(fifo_level)
   );

   always #5 clk30 = ~clk30;

   typedef struct {int c; logic [23:0] rgb;} exp_t;
   exp_t        exp_q[$];
   logic [24:0] wq[$];
   logic [24:0] mq[$];
   logic [23:0] seen_q[$];
   int          cyc = 0, n_chk = 0, n_pass = 0, wr_prob = 90;
   int          m_mode = 0, m_cnt = 0;
   bit          m_seen = 0, m_under = 0, m_sync = 0;
   logic [23:0] m_rgb = BLACK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic logic [31:0] sq(input int i);
      return (i < seen_q.size()) ? 32'(seen_q[i]) : 32'hdeadbeef;
   endfunction

   // Reference model: mode 0 idle, 1 emitting a line, 2 discarding to end-of-line marker.
   always @(posedge clk30 or negedge reset_n) begin : model
      bit          em, push, su, ss;
      logic [24:0] e;
      if (!reset_n) begin
         mq.delete(); exp_q.delete();
         m_mode = 0; m_cnt = 0; m_seen = 0; m_under = 0; m_sync = 0; m_rgb = BLACK;
      end else begin
         cyc++;
         em   = (mq.size() == 0);
         push = wr_valid && (mq.size() < DEPTH);
         su = 0; ss = 0;
         if (line_start) begin
            if (m_mode != 0) ss = 1;
            m_mode = 1; m_cnt = 0; m_seen = 0;
         end else if (m_mode == 1 && newpixel) begin
            if (m_seen) begin
               m_rgb = BLACK; ss = 1;
            end else if (em) begin
               m_rgb = BLACK; su = 1;
            end else begin
               e = mq.pop_front();
               m_rgb = e[23:0];
               if (e[24]) m_seen = 1;
            end
            exp_q.push_back('{cyc, m_rgb});
            m_cnt++;
            if (m_cnt == LINE) begin
               if (m_seen) m_mode = 0;
               else begin m_mode = 2; ss = 1; end
            end
         end else if (m_mode == 2 && !em) begin
            e = mq.pop_front();
            if (e[24]) m_mode = 0;
         end
         if (push) begin
            mq.push_back({wr_last, wr_data});
            void'(wq.pop_front());
         end
         if (su) m_under = 1; else if (clear_err) m_under = 0;
         if (ss) m_sync = 1;  else if (clear_err) m_sync = 0;
      end
   end

   always @(negedge clk30) begin : monitor
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
         e = exp_q.pop_front();
         chk("pix_valid", 32'(pix_valid), 32'd1);
         chk("pix_rgb_out", 32'(pix_rgb), 32'(e.rgb));
      end else begin
         chk("no_spurious_valid", 32'(pix_valid), 32'd0);
      end
      if (pix_valid) seen_q.push_back(pix_rgb);
      chk("pix_rgb_held", 32'(pix_rgb), 32'(m_rgb));
      chk("underflow", 32'(underflow), 32'(m_under));
      chk("sync_err", 32'(sync_err), 32'(m_sync));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
   end

   task automatic tick();
      @(posedge clk30); #1;
      newpixel = 0; line_start = 0; clear_err = 0;
      if (wq.size() > 0 && int'($urandom_range(0, 99)) < wr_prob) begin
         wr_valid = 1; wr_data = wq[0][23:0]; wr_last = wq[0][24];
      end else begin
         wr_valid = 0; wr_data = 24'($urandom); wr_last = 1'($urandom);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(1, 2)) tick();
         tick(); newpixel = 1;
      end
   endtask

   task automatic pulse_ls();  tick(); line_start = 1; endtask
   task automatic pulse_clr(); tick(); clear_err = 1;  endtask

   task automatic load(input logic [23:0] base, input int n, input int last_at);
      for (int i = 0; i < n; i++) wq.push_back({(i == last_at), base + 24'(i)});
   endtask

   task automatic drain_wait();
      int k = 0;
      while (wq.size() > 0 && k < 3000) begin tick(); k++; end
      chk("writer_drain_timeout", 32'(wq.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk30);
      #1;
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_pix_rgb", 32'(pix_rgb), 32'(BLACK));
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_sync_err", 32'(sync_err), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      reset_n = 1;

      // nominal line
      load(24'd0, 352, 351); idle(30);
      pulse_ls(); seen_q.delete(); strobes(352); idle(40);
      chk("nominal_count", 32'(seen_q.size()), 32'd352);
      for (int i = 0; i < 352; i++) chk("nominal_order", sq(i), 32'(i));
      chk("nominal_underflow", 32'(underflow), 32'd0);
      chk("nominal_sync", 32'(sync_err), 32'd0);
      chk("nominal_level", 32'(fifo_level), 32'd0);

      // underflow
      wr_prob = 100;
      load(24'h1000, 5, -1); drain_wait(); idle(3);
      pulse_ls(); seen_q.delete(); strobes(10);
      load(24'h1005, 342, 341); strobes(342); idle(40);
      chk("under_flag", 32'(underflow), 32'd1);
      chk("under_sync", 32'(sync_err), 32'd0);
      chk("under_pix4", sq(4), 32'h1004);
      for (int i = 5; i < 10; i++) chk("under_black", sq(i), 32'(BLACK));
      chk("under_pix10", sq(10), 32'h1005);
      chk("under_last", sq(351), 32'h1005 + 32'd341);
      pulse_clr(); tick();
      chk("under_cleared", 32'(underflow), 32'd0);

      // short line
      wr_prob = 90;
      load(24'h2000, 300, 299); idle(20);
      pulse_ls(); seen_q.delete(); strobes(352); idle(20);
      chk("short_count", 32'(seen_q.size()), 32'd352);
      chk("short_pix299", sq(299), 32'h2000 + 32'd299);
      chk("short_pad300", sq(300), 32'(BLACK));
      chk("short_pad351", sq(351), 32'(BLACK));
      chk("short_sync", 32'(sync_err), 32'd1);
      chk("short_underflow", 32'(underflow), 32'd0);
      chk("short_level", 32'(fifo_level), 32'd0);

      // long line followed by a nominal line
      pulse_clr();
      load(24'h3000, 360, 359); load(24'h4000, 352, 351); idle(20);
      pulse_ls(); seen_q.delete(); strobes(352); idle(20);
      chk("long_count", 32'(seen_q.size()), 32'd352);
      chk("long_pix351", sq(351), 32'h3000 + 32'd351);
      chk("long_sync", 32'(sync_err), 32'd1);
      pulse_clr(); idle(2); seen_q.delete();
      pulse_ls(); strobes(352); idle(40);
      chk("next_first", sq(0), 32'h4000);
      chk("next_count", 32'(seen_q.size()), 32'd352);
      chk("next_sync", 32'(sync_err), 32'd0);
      chk("next_level", 32'(fifo_level), 32'd0);

      // full / backpressure
      wr_prob = 100;
      load(24'h5000, 400, 351); idle(30);
      chk("full_level", 32'(fifo_level), 32'd16);
      chk("full_wr_ready", 32'(wr_ready), 32'd0);
      pulse_ls(); tick(); newpixel = 1; tick();
      chk("pop_level", 32'(fifo_level), 32'd15);
      chk("pop_wr_ready", 32'(wr_ready), 32'd1);
      tick();
      chk("refill_level", 32'(fifo_level), 32'd16);
      chk("refill_wr_ready", 32'(wr_ready), 32'd0);

      // reset at pixel 100, then resync
      strobes(99);
      reset_n = 0; wq.delete(); wr_valid = 0; newpixel = 0; line_start = 0;
      #1;
      chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("mid_rst_pix_rgb", 32'(pix_rgb), 32'(BLACK));
      chk("mid_rst_level", 32'(fifo_level), 32'd0);
      chk("mid_rst_underflow", 32'(underflow), 32'd0);
      chk("mid_rst_sync", 32'(sync_err), 32'd0);
      idle(2); reset_n = 1;
      wr_prob = 90;
      load(24'h6000, 10, -1); load(24'h7000, 352, 351); idle(20);
      pulse_ls(); strobes(10); idle(2);
      chk("resync_pre_sync", 32'(sync_err), 32'd0);
      seen_q.delete();
      pulse_ls(); tick();
      chk("resync_sync", 32'(sync_err), 32'd1);
      strobes(352); idle(40);
      chk("resync_count", 32'(seen_q.size()), 32'd352);
      chk("resync_first", sq(0), 32'h7000);
      chk("resync_last", sq(351), 32'h7000 + 32'd351);
      chk("resync_level", 32'(fifo_level), 32'd0);

      idle(5);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
